// File: rtl/me_mv_select.sv
// Motion-vector decision stage: tracks the minimum 16x16 SAD and each 8x8 SAD
// over one raster scan of the search window and reports the winners with their MVs.
module me_mv_select #(
  parameter int SEARCH_RANGE = 16,
  parameter int MV_W         = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sad_valid,
  output logic                sad_ready,
  input  logic [15:0]         sad16x16,
  input  logic [55:0]         sad8x8,
  output logic [15:0]         best_sad16x16,
  output logic [MV_W-1:0]     best_mv16_x,
  output logic [MV_W-1:0]     best_mv16_y,
  output logic [55:0]         best_sad8x8,
  output logic [4*MV_W-1:0]   best_mv8_x,
  output logic [4*MV_W-1:0]   best_mv8_y,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Candidate coordinates are kept as two's-complement bit patterns of width MV_W.
  localparam logic [MV_W-1:0] C_MIN = MV_W'(-SEARCH_RANGE);
  localparam logic [MV_W-1:0] C_MAX = MV_W'(SEARCH_RANGE - 1);
  localparam logic [MV_W-1:0] C_ONE = MV_W'(1);

  logic [1:0]         state_q, state_d;
  logic [MV_W-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic [15:0]        sad16_q, sad16_d;
  logic [MV_W-1:0]    mv16x_q, mv16x_d, mv16y_q, mv16y_d;
  logic [55:0]        sad8_q, sad8_d;
  logic [4*MV_W-1:0]  mv8x_q, mv8x_d, mv8y_q, mv8y_d;
  logic               ready_q, busy_q, done_q;
  logic               accept_s;
  logic               last_s;

  assign accept_s = (state_q == S_SCAN) && sad_valid;
  assign last_s   = (cx_q == C_MAX) && (cy_q == C_MAX);

  // Next-state logic: FSM, raster counters and per-partition minimum tracking.
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    sad16_d = sad16_q;
    mv16x_d = mv16x_q;
    mv16y_d = mv16y_q;
    sad8_d  = sad8_q;
    mv8x_d  = mv8x_q;
    mv8y_d  = mv8y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sad16_d = 16'hFFFF;
          sad8_d  = {4{14'h3FFF}};
          mv16x_d = '0;
          mv16y_d = '0;
          mv8x_d  = '0;
          mv8y_d  = '0;
          cx_d    = C_MIN;
          cy_d    = C_MIN;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (accept_s) begin
          // Strict compare keeps the earlier raster candidate on ties.
          if (sad16x16 < sad16_q) begin
            sad16_d = sad16x16;
            mv16x_d = cx_q;
            mv16y_d = cy_q;
          end else begin
            sad16_d = sad16_q;
          end
          for (int p = 0; p < 4; p++) begin
            if (sad8x8[p*14 +: 14] < sad8_q[p*14 +: 14]) begin
              sad8_d[p*14 +: 14]   = sad8x8[p*14 +: 14];
              mv8x_d[p*MV_W +: MV_W] = cx_q;
              mv8y_d[p*MV_W +: MV_W] = cy_q;
            end else begin
              sad8_d[p*14 +: 14] = sad8_q[p*14 +: 14];
            end
          end
          if (cx_q == C_MAX) begin
            cx_d = C_MIN;
            cy_d = cy_q + C_ONE;
          end else begin
            cx_d = cx_q + C_ONE;
          end
          if (last_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
          end
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; status outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      sad16_q <= 16'h0000;
      mv16x_q <= '0;
      mv16y_q <= '0;
      sad8_q  <= 56'h0;
      mv8x_q  <= '0;
      mv8y_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      sad16_q <= sad16_d;
      mv16x_q <= mv16x_d;
      mv16y_q <= mv16y_d;
      sad8_q  <= sad8_d;
      mv8x_q  <= mv8x_d;
      mv8y_q  <= mv8y_d;
      ready_q <= (state_d == S_SCAN);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign sad_ready     = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign best_sad16x16 = sad16_q;
  assign best_mv16_x   = mv16x_q;
  assign best_mv16_y   = mv16y_q;
  assign best_sad8x8   = sad8_q;
  assign best_mv8_x    = mv8x_q;
  assign best_mv8_y    = mv8y_q;

endmodule

// File: tb/tb_me_mv_select.sv
// Scoreboard bench for me_mv_select with SEARCH_RANGE=2: the driver pushes the
// expected winners of each scan, a monitor pops and compares on every done pulse.
module tb_me_mv_select;
  localparam int SR = 2;
  localparam int MW = 6;
  localparam int N  = 4 * SR * SR;

  logic clk = 1'b0;
  logic rst, start, sad_valid, sad_ready, busy, done;
  logic [15:0] sad16x16, best_sad16x16;
  logic [55:0] sad8x8, best_sad8x8;
  logic [MW-1:0] best_mv16_x, best_mv16_y;
  logic [4*MW-1:0] best_mv8_x, best_mv8_y;

  me_mv_select #(.SEARCH_RANGE(SR), .MV_W(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .sad_valid(sad_valid), .sad_ready(sad_ready),
    .sad16x16(sad16x16), .sad8x8(sad8x8), .best_sad16x16(best_sad16x16),
    .best_mv16_x(best_mv16_x), .best_mv16_y(best_mv16_y), .best_sad8x8(best_sad8x8),
    .best_mv8_x(best_mv8_x), .best_mv8_y(best_mv8_y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     s16;
    logic [MW-1:0]   x16, y16;
    logic [55:0]     s8;
    logic [4*MW-1:0] x8, y8;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int c16[N];
  int c8[N][4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MV of raster index idx; a partition that never improved reports 0.
  function automatic logic [MW-1:0] mv_x(input int idx);
    if (idx < 0) return '0;
    return MW'(idx % (2 * SR) - SR);
  endfunction

  function automatic logic [MW-1:0] mv_y(input int idx);
    if (idx < 0) return '0;
    return MW'(idx / (2 * SR) - SR);
  endfunction

  // Reference: first raster index holding the minimum value below the all-ones start.
  function automatic exp_t model();
    exp_t e;
    int best, bi;
    best = 32'hFFFF; bi = -1;
    for (int i = 0; i < N; i++) if (c16[i] < best) begin best = c16[i]; bi = i; end
    e.s16 = best[15:0]; e.x16 = mv_x(bi); e.y16 = mv_y(bi);
    for (int p = 0; p < 4; p++) begin
      best = 32'h3FFF; bi = -1;
      for (int i = 0; i < N; i++) if (c8[i][p] < best) begin best = c8[i][p]; bi = i; end
      e.s8[p*14 +: 14] = best[13:0];
      e.x8[p*MW +: MW] = mv_x(bi);
      e.y8[p*MW +: MW] = mv_y(bi);
    end
    return e;
  endfunction

  task automatic fill(input int v16, input int v8);
    for (int i = 0; i < N; i++) begin
      c16[i] = v16;
      for (int p = 0; p < 4; p++) c8[i][p] = v8;
    end
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < N; i++) begin
      c16[i] = int'($urandom_range(hi, lo));
      for (int p = 0; p < 4; p++) c8[i][p] = int'($urandom_range(hi, lo));
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_sad16"}, 64'(best_sad16x16), 64'd0);
    chk({name, "_mv16"}, 64'({best_mv16_x, best_mv16_y}), 64'd0);
    chk({name, "_sad8"}, 64'(best_sad8x8), 64'd0);
    chk({name, "_mv8"}, 64'({best_mv8_x, best_mv8_y}), 64'd0);
    chk({name, "_ctl"}, 64'({sad_ready, busy, done}), 64'd0);
  endtask

  // Drive one scan; abort_at >= 0 applies rst before that candidate.
  task automatic drive_scan(input bit stall, input bit inj_start, input int abort_at);
    int gaps;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("ready_after_start", 64'(sad_ready), 64'd1);
    for (int i = 0; i < N; i++) begin
      gaps = stall ? int'($urandom_range(2, 0)) : 0;
      if (inj_start && i == 5) gaps = gaps + 1;
      for (int g = 0; g < gaps; g++) begin
        sad_valid = 1'b0;
        sad16x16 = 16'($urandom);
        sad8x8 = 56'({$urandom, $urandom});
        start = (inj_start && i == 5 && g == 0);
        @(negedge clk);
        start = 1'b0;
      end
      if (abort_at == i) begin
        sad_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        return;
      end
      sad_valid = 1'b1;
      sad16x16 = c16[i][15:0];
      sad8x8 = {c8[i][3][13:0], c8[i][2][13:0], c8[i][1][13:0], c8[i][0][13:0]};
      @(negedge clk);
      if (i < N - 1) chk("no_early_done", 64'(done), 64'd0);
    end
    sad_valid = 1'b0;
    chk("done_after_last", 64'({done, sad_ready, busy}), 64'b101);
    @(negedge clk);
    chk("idle_after_done", 64'({done, busy}), 64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sad16", 64'(best_sad16x16), 64'(e.s16));
        chk("mv16", 64'({best_mv16_x, best_mv16_y}), 64'({e.x16, e.y16}));
        chk("sad8", 64'(best_sad8x8), 64'(e.s8));
        chk("mv8x", 64'(best_mv8_x), 64'(e.x8));
        chk("mv8y", 64'(best_mv8_y), 64'(e.y8));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b1; sad_valid = 1'b0; sad16x16 = 16'd0; sad8x8 = 56'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    chk("no_scan_from_rst_start", 64'(busy), 64'd0);

    fill(100, 1000); c16[9] = 40;
    sb.push_back(model()); drive_scan(1'b0, 1'b0, -1);

    fill(50, 50);
    sb.push_back(model()); drive_scan(1'b0, 1'b0, -1);

    fill(100, 200);
    c16[3] = 20; c8[0][0] = 5; c8[15][1] = 7; c8[6][2] = 3; c8[12][3] = 9;
    sb.push_back(model()); drive_scan(1'b0, 1'b0, -1);

    fill(50, 50);
    sb.push_back(model()); drive_scan(1'b1, 1'b1, -1);

    fill(32'hFFFF, 32'h3FFF);
    sb.push_back(model()); drive_scan(1'b0, 1'b0, -1);

    fill(1, 1);
    drive_scan(1'b0, 1'b0, 7);
    chk_zero("abort");
    fill_rand(10, 40);
    sb.push_back(model()); drive_scan(1'b0, 1'b0, -1);

    repeat (4) begin
      fill_rand(0, 30);
      sb.push_back(model()); drive_scan(1'($urandom_range(1, 0)), 1'b0, -1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
